// File: rtl/gpu_line_rasterizer.sv
// rtl/gpu_line_rasterizer.sv - Bresenham line engine emitting one pixel per handshake
module gpu_line_rasterizer #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_BITS-1:0]  x1_i,
  input  logic [HEIGHT_BITS-1:0] y1_i,
  input  logic [WIDTH_BITS-1:0]  x2_i,
  input  logic [HEIGHT_BITS-1:0] y2_i,
  input  logic                   run_i,
  input  logic                   pixel_ready_i,
  output logic [WIDTH_BITS-1:0]  pixel_x_o,
  output logic [HEIGHT_BITS-1:0] pixel_y_o,
  output logic                   pixel_valid_o,
  output logic                   finished_o,
  output logic                   busy_o
);

  // Error terms carry one sign bit plus one headroom bit over the widest axis;
  // the doubled error needs one more bit on top of that.
  localparam int MAXB = (WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS;
  localparam int EW   = MAXB + 2;
  localparam int E2W  = EW + 1;

  localparam logic [WIDTH_BITS-1:0]  X_ONE  = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [HEIGHT_BITS-1:0] Y_ONE  = {{(HEIGHT_BITS-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0]   ZERO_E = '0;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE,
    HOLD
  } state_t;

  state_t state;

  logic [WIDTH_BITS-1:0]  x;
  logic [WIDTH_BITS-1:0]  xe;
  logic [HEIGHT_BITS-1:0] y;
  logic [HEIGHT_BITS-1:0] ye;
  logic signed [EW-1:0]   dx;
  logic signed [EW-1:0]   dy;
  logic signed [EW-1:0]   err;
  // Step direction flags: 1 means the coordinate decrements.
  logic                   sx;
  logic                   sy;

  logic [WIDTH_BITS-1:0]  adx_u;
  logic [HEIGHT_BITS-1:0] ady_u;
  logic signed [EW-1:0]   dx_init;
  logic signed [EW-1:0]   dy_init;

  logic signed [E2W-1:0]  e2;
  logic signed [E2W-1:0]  dx_w;
  logic signed [E2W-1:0]  dy_w;
  logic                   step_x;
  logic                   step_y;
  logic                   at_end;
  logic signed [EW-1:0]   err_next;
  logic [WIDTH_BITS-1:0]  x_next;
  logic [HEIGHT_BITS-1:0] y_next;

  // Line setup terms derived straight from the endpoint inputs.
  always_comb begin
    adx_u   = (x2_i >= x1_i) ? (x2_i - x1_i) : (x1_i - x2_i);
    ady_u   = (y2_i >= y1_i) ? (y2_i - y1_i) : (y1_i - y2_i);
    dx_init = signed'({{(EW-WIDTH_BITS){1'b0}}, adx_u});
    dy_init = -signed'({{(EW-HEIGHT_BITS){1'b0}}, ady_u});
  end

  // One Bresenham step: both axis decisions use the same doubled error.
  always_comb begin
    e2       = {err, 1'b0};
    dx_w     = E2W'(dx);
    dy_w     = E2W'(dy);
    step_x   = (e2 >= dy_w);
    step_y   = (e2 <= dx_w);
    err_next = err + (step_x ? dy : ZERO_E) + (step_y ? dx : ZERO_E);
    x_next   = x;
    y_next   = y;
    if (step_x) begin
      x_next = sx ? (x - X_ONE) : (x + X_ONE);
    end
    if (step_y) begin
      y_next = sy ? (y - Y_ONE) : (y + Y_ONE);
    end
    at_end   = (x == xe) && (y == ye);
  end

  // Control FSM with registered handshake, completion and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      xe            <= '0;
      ye            <= '0;
      dx            <= '0;
      dy            <= '0;
      err           <= '0;
      sx            <= 1'b0;
      sy            <= 1'b0;
      pixel_valid_o <= 1'b0;
      finished_o    <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          finished_o <= 1'b0;
          if (run_i) begin
            x             <= x1_i;
            y             <= y1_i;
            xe            <= x2_i;
            ye            <= y2_i;
            dx            <= dx_init;
            dy            <= dy_init;
            err           <= dx_init + dy_init;
            sx            <= !(x1_i < x2_i);
            sy            <= !(y1_i < y2_i);
            pixel_valid_o <= 1'b1;
            busy_o        <= 1'b1;
            state         <= DRAW;
          end
        end
        DRAW: begin
          if (pixel_valid_o && pixel_ready_i) begin
            if (at_end) begin
              pixel_valid_o <= 1'b0;
              finished_o    <= 1'b1;
              state         <= DONE;
            end else begin
              x   <= x_next;
              y   <= y_next;
              err <= err_next;
            end
          end
        end
        DONE: begin
          finished_o <= 1'b0;
          if (run_i) begin
            state <= HOLD;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        HOLD: begin
          // A run strobe still high from the finished line must not restart it.
          if (!run_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          pixel_valid_o <= 1'b0;
          finished_o    <= 1'b0;
          busy_o        <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign pixel_x_o = x;
  assign pixel_y_o = y;

endmodule
